// File: rtl/keyscan_ctrl.sv
// ---------------------------------------------------------------------------
// keyscan_ctrl
//
// Purpose:
//   Scans a 4x4 active-low keypad one column at a time, debounces the first
//   key it finds, emits its hex code once with a one-cycle strobe, and then
//   waits for a debounced release before scanning resumes. The key_code /
//   key_en pair feeds the sin / en inputs of a downstream 4-bit shift register.
//
// Parameters:
//   SCAN_DIV  - clock cycles each column is driven before the rows are sampled
//   DB_CYCLES - consecutive stable cycles needed for press and for release
//
// Ports:
//   clk      in   1  single clock, all state changes on its rising edge
//   reset    in   1  asynchronous, active-high reset
//   rows     in   4  keypad row lines, active-low, asynchronous to clk
//   cols     out  4  keypad column drive, active-low, exactly one bit low
//   key_code out  4  hex code of the last accepted key
//   key_en   out  1  one-cycle pulse when a key is accepted
//   key_held out  1  high while the accepted key is held, through release
// ---------------------------------------------------------------------------
module keyscan_ctrl #(
  parameter int SCAN_DIV  = 4,
  parameter int DB_CYCLES = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] rows,
  output logic [3:0] cols,
  output logic [3:0] key_code,
  output logic       key_en,
  output logic       key_held
);

  // One counter width serves both the column dwell and the debounce count,
  // so it is sized for the larger of the two terminal values.
  localparam int MAX_CNT = (SCAN_DIV > DB_CYCLES) ? SCAN_DIV : DB_CYCLES;
  localparam int CW      = ($clog2(MAX_CNT) < 1) ? 1 : $clog2(MAX_CNT);

  localparam logic [CW-1:0] DWELL_LAST = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] DB_LAST    = CW'(DB_CYCLES - 1);

  typedef enum logic [2:0] {
    SCAN,
    DEBOUNCE,
    EMIT,
    HOLD,
    RELEASE
  } state_t;

  // Synchronizer and FSM registers.
  logic [3:0]    rowsMeta_q;
  logic [3:0]    rowsSync_q;

  state_t        state_q,   state_d;
  logic [1:0]    colIdx_q,  colIdx_d;
  logic [1:0]    rowIdx_q,  rowIdx_d;
  logic [CW-1:0] dwell_q,   dwell_d;
  logic [CW-1:0] dbCnt_q,   dbCnt_d;

  // Registered outputs.
  logic [3:0]    cols_q,    cols_d;
  logic [3:0]    keyCode_q, keyCode_d;
  logic          keyEn_q,   keyEn_d;
  logic          keyHeld_q, keyHeld_d;

  // Level of the latched row line as seen through the synchronizer.
  logic          rowLow;

  // Active-low one-hot drive pattern for a column index.
  function automatic logic [3:0] colDrive(input logic [1:0] idx);
    return ~(4'b0001 << idx);
  endfunction

  // Index of the lowest-numbered row that is pulled low; scanning from the
  // top down lets the lowest index win.
  function automatic logic [1:0] lowestLow(input logic [3:0] r);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!r[i]) begin
        idx = 2'(i);
      end
    end
    return idx;
  endfunction

  // Keypad legend, addressed by {row, col}.
  function automatic logic [3:0] keyMap(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] code;
    case ({r, c})
      4'b00_00: code = 4'h1;
      4'b00_01: code = 4'h2;
      4'b00_10: code = 4'h3;
      4'b00_11: code = 4'hA;
      4'b01_00: code = 4'h4;
      4'b01_01: code = 4'h5;
      4'b01_10: code = 4'h6;
      4'b01_11: code = 4'hB;
      4'b10_00: code = 4'h7;
      4'b10_01: code = 4'h8;
      4'b10_10: code = 4'h9;
      4'b10_11: code = 4'hC;
      4'b11_00: code = 4'hE;
      4'b11_01: code = 4'h0;
      4'b11_10: code = 4'hF;
      default:  code = 4'hD;
    endcase
    return code;
  endfunction

  // Two-flop synchronizer for the asynchronous row lines. Idle rows read
  // high, so the flops come out of reset at all-ones and no phantom press
  // is seen right after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rowsMeta_q <= 4'hF;
      rowsSync_q <= 4'hF;
    end else begin
      rowsMeta_q <= rows;
      rowsSync_q <= rowsMeta_q;
    end
  end

  assign rowLow = ~rowsSync_q[rowIdx_q];

  // Next-state logic for the scanner. Outputs are computed alongside the
  // state so that they are registered together with it: cols changes in the
  // same edge as the column index, and key_en / key_held line up with the
  // cycle after EMIT and with HOLD/RELEASE respectively.
  always_comb begin
    state_d   = state_q;
    colIdx_d  = colIdx_q;
    rowIdx_d  = rowIdx_q;
    dwell_d   = dwell_q;
    dbCnt_d   = dbCnt_q;
    cols_d    = cols_q;
    keyCode_d = keyCode_q;
    keyEn_d   = 1'b0;
    keyHeld_d = keyHeld_q;

    case (state_q)
      SCAN: begin
        if (dwell_q == DWELL_LAST) begin
          dwell_d = '0;
          if (rowsSync_q == 4'hF) begin
            colIdx_d = colIdx_q + 2'd1;
            cols_d   = colDrive(colIdx_q + 2'd1);
          end else begin
            rowIdx_d = lowestLow(rowsSync_q);
            dbCnt_d  = '0;
            state_d  = DEBOUNCE;
          end
        end else begin
          dwell_d = dwell_q + 1'b1;
        end
      end

      // A single high sample on the latched row abandons the press and
      // rescans the same column from a fresh dwell.
      DEBOUNCE: begin
        if (rowLow) begin
          if (dbCnt_q == DB_LAST) begin
            state_d = EMIT;
          end else begin
            dbCnt_d = dbCnt_q + 1'b1;
          end
        end else begin
          state_d = SCAN;
          dwell_d = '0;
        end
      end

      EMIT: begin
        keyCode_d = keyMap(rowIdx_q, colIdx_q);
        keyEn_d   = 1'b1;
        keyHeld_d = 1'b1;
        state_d   = HOLD;
      end

      HOLD: begin
        if (!rowLow) begin
          dbCnt_d = '0;
          state_d = RELEASE;
        end
      end

      // Any low sample during release restarts the release debounce from
      // HOLD; scanning moves on to the next column once release is stable.
      RELEASE: begin
        if (!rowLow) begin
          if (dbCnt_q == DB_LAST) begin
            state_d   = SCAN;
            dwell_d   = '0;
            keyHeld_d = 1'b0;
            colIdx_d  = colIdx_q + 2'd1;
            cols_d    = colDrive(colIdx_q + 2'd1);
          end else begin
            dbCnt_d = dbCnt_q + 1'b1;
          end
        end else begin
          dbCnt_d = '0;
          state_d = HOLD;
        end
      end

      default: begin
        state_d = SCAN;
      end
    endcase
  end

  // State and output registers; reset aborts any press in progress.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= SCAN;
      colIdx_q  <= 2'd0;
      rowIdx_q  <= 2'd0;
      dwell_q   <= '0;
      dbCnt_q   <= '0;
      cols_q    <= 4'b1110;
      keyCode_q <= 4'h0;
      keyEn_q   <= 1'b0;
      keyHeld_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      colIdx_q  <= colIdx_d;
      rowIdx_q  <= rowIdx_d;
      dwell_q   <= dwell_d;
      dbCnt_q   <= dbCnt_d;
      cols_q    <= cols_d;
      keyCode_q <= keyCode_d;
      keyEn_q   <= keyEn_d;
      keyHeld_q <= keyHeld_d;
    end
  end

  assign cols     = cols_q;
  assign key_code = keyCode_q;
  assign key_en   = keyEn_q;
  assign key_held = keyHeld_q;

endmodule

// File: tb/tb_keyscan_ctrl.sv
// ---------------------------------------------------------------------------
// tb_keyscan_ctrl
//
// Self-checking bench for keyscan_ctrl. A behavioural keypad (a 16-bit mask
// of pressed keys) pulls a row low whenever a pressed key sits in the column
// the DUT currently drives. Expected timing is derived from the scanning and
// debounce rules: each column is sampled at the end of its dwell, rows reach
// the decision logic two edges after they change, an accepted press strobes
// key_en DB_CYCLES+1 edges after debounce starts, and key_held drops once
// DB_CYCLES+1 consecutive high samples follow the final release edge.
// ---------------------------------------------------------------------------
module tb_keyscan_ctrl;

  localparam int SCAN_DIV  = 4;
  localparam int DB_CYCLES = 8;
  localparam int SYNC_LAT  = 2;
  localparam int EN_LAT    = DB_CYCLES + 1;
  localparam int HELD_DROP = SYNC_LAT + 1 + DB_CYCLES;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  rowsIn;
  logic [3:0]  colsOut;
  logic [3:0]  keyCode;
  logic        keyEn;
  logic        keyHeld;

  logic [15:0] pressed = '0;
  logic [3:0]  keyMap [16];

  int cyc;
  int enCount;
  int enBase;
  int nCompared;
  int nMismatched;
  int curCol;
  int colStart;
  int emitAt;
  int relAt;
  int firstRel;

  keyscan_ctrl #(
    .SCAN_DIV (SCAN_DIV),
    .DB_CYCLES(DB_CYCLES)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .rows    (rowsIn),
    .cols    (colsOut),
    .key_code(keyCode),
    .key_en  (keyEn),
    .key_held(keyHeld)
  );

  always #5 clk = ~clk;

  // Keypad matrix: a row reads low while any pressed key on it is driven.
  always_comb begin
    rowsIn = 4'hF;
    for (int r = 0; r < 4; r++) begin
      if ((pressed[r*4 +: 4] & ~colsOut) != 4'h0) begin
        rowsIn[r] = 1'b0;
      end
    end
  end

  function automatic logic [3:0] colDrive(int c);
    logic [3:0] one;
    one = 4'b0001;
    return ~(one << c);
  endfunction

  function automatic logic [15:0] keyBit(int r, int c);
    logic [15:0] one;
    one = 16'h0001;
    return one << (r * 4 + c);
  endfunction

  // Edge at which debounce starts for a key in column toCol, pressed at the
  // moment column fromCol began its dwell at edge start.
  function automatic int entryEdge(int start, int fromCol, int toCol);
    return start + SCAN_DIV * ((((toCol - fromCol) % 4) + 4) % 4 + 1);
  endfunction

  // Advance one clock and sample just after the edge; key_en pulses are
  // counted here so every cycle is observed.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (keyEn === 1'b1) begin
      enCount++;
    end
  endtask

  task automatic tickTo(int target);
    while (cyc < target) begin
      tick();
    end
  endtask

  task automatic applyStimulus(logic [15:0] mask);
    pressed = mask;
  endtask

  task automatic checkOutput(string tag, logic [31:0] observed, logic [31:0] expected);
    nCompared++;
    assert (observed === expected) else begin
      nMismatched++;
      $error("[TB] FAIL %s at cycle %0d: observed %0h, expected %0h", tag, cyc, observed, expected);
    end
  endtask

  // Linear sequence of directed and randomized scenarios.
  initial begin
    nCompared   = 0;
    nMismatched = 0;
    enCount     = 0;
    cyc         = 0;
    keyMap = '{4'h1, 4'h2, 4'h3, 4'hA,
               4'h4, 4'h5, 4'h6, 4'hB,
               4'h7, 4'h8, 4'h9, 4'hC,
               4'hE, 4'h0, 4'hF, 4'hD};

    // Reset values and idle scanning.
    reset = 1'b1;
    applyStimulus('0);
    #12;
    checkOutput("rst_cols", colsOut, 4'b1110);
    checkOutput("rst_code", keyCode, 4'h0);
    checkOutput("rst_en", keyEn, 1'b0);
    checkOutput("rst_held", keyHeld, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    cyc   = 0;
    checkOutput("idle_start_col0", colsOut, 4'b1110);
    for (int i = 0; i < 32; i++) begin
      tick();
      checkOutput("idle_cols", colsOut, colDrive((cyc / SCAN_DIV) % 4));
    end
    checkOutput("idle_no_en", enCount, 0);

    // Key '6' (row 1, column 2) held for 200 cycles.
    colStart = cyc;
    curCol   = (cyc / SCAN_DIV) % 4;
    enBase   = enCount;
    applyStimulus(keyBit(1, 2));
    emitAt = entryEdge(colStart, curCol, 2) + EN_LAT;
    tickTo(emitAt - 1);
    checkOutput("k6_no_early_en", enCount - enBase, 0);
    checkOutput("k6_held_before", keyHeld, 1'b0);
    tick();
    checkOutput("k6_en", keyEn, 1'b1);
    checkOutput("k6_code", keyCode, keyMap[6]);
    checkOutput("k6_held", keyHeld, 1'b1);
    tick();
    checkOutput("k6_en_one_cycle", keyEn, 1'b0);
    tickTo(colStart + 200);
    checkOutput("k6_single_en", enCount - enBase, 1);
    applyStimulus('0);
    relAt = cyc;
    tickTo(relAt + HELD_DROP - 1);
    checkOutput("k6_held_release_db", keyHeld, 1'b1);
    tick();
    checkOutput("k6_held_drop", keyHeld, 1'b0);
    checkOutput("k6_next_col", colsOut, colDrive(3));
    checkOutput("k6_code_kept", keyCode, keyMap[6]);
    checkOutput("k6_total_en", enCount - enBase, 1);
    curCol   = 3;
    colStart = cyc;

    // Bounce: row 0 low on column 0 for 3 cycles only.
    tickTo(colStart + SCAN_DIV);
    curCol   = 0;
    colStart = cyc;
    checkOutput("bnc_col0", colsOut, colDrive(0));
    enBase = enCount;
    applyStimulus(keyBit(0, 0));
    tickTo(colStart + 3);
    applyStimulus('0);
    relAt = cyc;
    tickTo(relAt + SYNC_LAT + 1 + SCAN_DIV - 1);
    checkOutput("bnc_resume_col0", colsOut, colDrive(0));
    checkOutput("bnc_held", keyHeld, 1'b0);
    tick();
    checkOutput("bnc_next_col1", colsOut, colDrive(1));
    checkOutput("bnc_no_en", enCount - enBase, 0);
    checkOutput("bnc_code_kept", keyCode, keyMap[6]);
    curCol   = 1;
    colStart = cyc;

    // Key '0' (row 3, column 1) held, then row 2 on column 1 added mid-hold.
    enBase = enCount;
    applyStimulus(keyBit(3, 1));
    emitAt = entryEdge(colStart, curCol, 1) + EN_LAT;
    tickTo(emitAt - 1);
    checkOutput("k0_no_early_en", enCount - enBase, 0);
    tick();
    checkOutput("k0_en", keyEn, 1'b1);
    checkOutput("k0_code", keyCode, keyMap[13]);
    tickTo(emitAt + 20);
    applyStimulus(keyBit(3, 1) | keyBit(2, 1));
    tickTo(emitAt + 60);
    checkOutput("k0_second_key_ignored", enCount - enBase, 1);
    checkOutput("k0_held", keyHeld, 1'b1);
    checkOutput("k0_code_kept", keyCode, keyMap[13]);
    applyStimulus('0);
    relAt = cyc;
    tickTo(relAt + HELD_DROP - 1);
    checkOutput("k0_held_release_db", keyHeld, 1'b1);
    tick();
    checkOutput("k0_held_drop", keyHeld, 1'b0);
    checkOutput("k0_next_col", colsOut, colDrive(2));
    checkOutput("k0_total_en", enCount - enBase, 1);
    curCol   = 2;
    colStart = cyc;

    // Release glitch: high 5 cycles, low 1, then high for good.
    enBase = enCount;
    applyStimulus(keyBit(0, 2));
    emitAt = entryEdge(colStart, curCol, 2) + EN_LAT;
    tickTo(emitAt);
    checkOutput("gl_en", keyEn, 1'b1);
    checkOutput("gl_code", keyCode, keyMap[2]);
    tickTo(emitAt + 25);
    applyStimulus('0);
    firstRel = cyc;
    tickTo(firstRel + 5);
    applyStimulus(keyBit(0, 2));
    tick();
    applyStimulus('0);
    relAt = cyc;
    tickTo(firstRel + HELD_DROP);
    checkOutput("gl_held_after_glitch", keyHeld, 1'b1);
    tickTo(relAt + HELD_DROP - 1);
    checkOutput("gl_held_final_run", keyHeld, 1'b1);
    tick();
    checkOutput("gl_held_drop", keyHeld, 1'b0);
    checkOutput("gl_next_col", colsOut, colDrive(3));
    checkOutput("gl_total_en", enCount - enBase, 1);
    curCol   = 3;
    colStart = cyc;

    // Randomized presses, optionally with a second key added while held.
    for (int it = 0; it < 6; it++) begin
      int r;
      int c;
      int h;
      logic [15:0] mask;
      r = $urandom_range(3);
      c = $urandom_range(3);
      mask = keyBit(r, c);
      enBase = enCount;
      applyStimulus(mask);
      emitAt = entryEdge(colStart, curCol, c) + EN_LAT;
      tickTo(emitAt - 1);
      checkOutput("rnd_no_early_en", enCount - enBase, 0);
      tick();
      checkOutput("rnd_en", keyEn, 1'b1);
      checkOutput("rnd_code", keyCode, keyMap[r*4 + c]);
      h = $urandom_range(40, 10);
      if ($urandom_range(1) == 1) begin
        tickTo(cyc + 2);
        applyStimulus(mask | keyBit($urandom_range(3), $urandom_range(3)));
      end
      tickTo(emitAt + h);
      checkOutput("rnd_held", keyHeld, 1'b1);
      checkOutput("rnd_single_en", enCount - enBase, 1);
      applyStimulus('0);
      relAt = cyc;
      tickTo(relAt + HELD_DROP - 1);
      checkOutput("rnd_held_release_db", keyHeld, 1'b1);
      tick();
      checkOutput("rnd_held_drop", keyHeld, 1'b0);
      checkOutput("rnd_next_col", colsOut, colDrive((c + 1) % 4));
      curCol   = (c + 1) % 4;
      colStart = cyc;
    end

    // Reset in the middle of debounce must not emit anything.
    enBase = enCount;
    applyStimulus(keyBit($urandom_range(3), curCol));
    tickTo(entryEdge(colStart, curCol, curCol) + 3);
    #3;
    reset = 1'b1;
    applyStimulus('0);
    #1;
    checkOutput("rdb_cols", colsOut, 4'b1110);
    checkOutput("rdb_code", keyCode, 4'h0);
    checkOutput("rdb_en", keyEn, 1'b0);
    tick();
    reset = 1'b0;
    cyc   = 0;
    checkOutput("rdb_resume_col0", colsOut, 4'b1110);
    tickTo(SCAN_DIV);
    checkOutput("rdb_next_col1", colsOut, colDrive(1));
    checkOutput("rdb_no_en", enCount - enBase, 0);
    curCol   = 1;
    colStart = cyc;

    // Asynchronous reset between edges while a key is held.
    begin
      int r;
      int c;
      r = $urandom_range(2);
      c = $urandom_range(3);
      enBase = enCount;
      applyStimulus(keyBit(r, c));
      emitAt = entryEdge(colStart, curCol, c) + EN_LAT;
      tickTo(emitAt);
      checkOutput("rh_en", keyEn, 1'b1);
      checkOutput("rh_code", keyCode, keyMap[r*4 + c]);
      tickTo(emitAt + 15);
      checkOutput("rh_held", keyHeld, 1'b1);
      #4;
      reset = 1'b1;
      #1;
      checkOutput("rh_async_cols", colsOut, 4'b1110);
      checkOutput("rh_async_code", keyCode, 4'h0);
      checkOutput("rh_async_en", keyEn, 1'b0);
      checkOutput("rh_async_held", keyHeld, 1'b0);
      applyStimulus('0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      cyc   = 0;
      checkOutput("rh_resume_col0", colsOut, 4'b1110);
      tickTo(SCAN_DIV - 1);
      checkOutput("rh_col0_dwell", colsOut, 4'b1110);
      tick();
      checkOutput("rh_next_col1", colsOut, colDrive(1));
      checkOutput("rh_total_en", enCount - enBase, 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/keyscan_ctrl.md
KEYSCAN_CTRL -- requirements
Module: keyscan_ctrl

Interface
REQ-001 The module SHALL have parameter SCAN_DIV, default 4: clock cycles each column is driven before rows are sampled.
REQ-002 The module SHALL have parameter DB_CYCLES, default 8: consecutive stable cycles required for press and for release debounce.
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The module SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The module SHALL have port rows, input, 4 bits: keypad row lines, active-low, asynchronous to clk.
REQ-006 The module SHALL have port cols, output, 4 bits: keypad column drive, active-low, one-hot-low.
REQ-007 The module SHALL have port key_code, output, 4 bits: hex code of the last accepted key; this is the sin of the downstream 4-bit shift register.
REQ-008 The module SHALL have port key_en, output, 1 bit: one-cycle pulse on key acceptance; this is the en of the downstream shift register.
REQ-009 The module SHALL have port key_held, output, 1 bit: high while an accepted key remains pressed, through its release debounce.

Function
REQ-010 rows SHALL pass through a 2-flop synchronizer (rows_s); all decisions use rows_s only.
REQ-011 The FSM SHALL have the states SCAN, DEBOUNCE, EMIT, HOLD and RELEASE.
REQ-012 In SCAN, cols SHALL equal ~(4'b0001 << col_idx), and a dwell counter SHALL count 0..SCAN_DIV-1.
REQ-013 At dwell count SCAN_DIV-1 with rows_s == 4'hF, col_idx SHALL advance, wrapping 3 -> 0, and the dwell SHALL restart.
REQ-014 At dwell count SCAN_DIV-1 with any rows_s bit low, the FSM SHALL latch col_idx and the lowest-index low row, clear the debounce counter and enter DEBOUNCE.
REQ-015 In DEBOUNCE, cols SHALL hold the latched column, and each cycle the latched rows_s bit is low the counter SHALL increment.
REQ-016 If the latched row reads high during DEBOUNCE, the FSM SHALL return to SCAN with the same col_idx and a cleared dwell, and SHALL NOT pulse key_en.
REQ-017 When the DEBOUNCE counter reaches DB_CYCLES-1 with the row still low, the FSM SHALL enter EMIT.
REQ-018 EMIT SHALL last exactly one cycle, registering key_code and asserting key_en = 1 in that cycle only, then the FSM SHALL enter HOLD.
REQ-019 The key map (row r, col c) SHALL be: r0: 1 2 3 A; r1: 4 5 6 B; r2: 7 8 9 C; r3: E 0 F D.
REQ-020 key_held SHALL be 1 in HOLD and RELEASE and 0 otherwise.
REQ-021 In HOLD, the latched row reading high SHALL move the FSM to RELEASE with the counter cleared.
REQ-022 In RELEASE, the counter SHALL increment on the latched row high and SHALL clear and return to HOLD on low.
REQ-023 At RELEASE count DB_CYCLES-1, the FSM SHALL go to SCAN with col_idx advanced (wrapped).
REQ-024 Other keys pressed during DEBOUNCE, HOLD or RELEASE SHALL be ignored, and no second key_en SHALL be emitted for a held key.
REQ-025 key_code SHALL hold its value between EMIT cycles.
REQ-026 Latency SHALL be key_en asserted exactly DB_CYCLES+1 cycles after DEBOUNCE entry for a clean press.
REQ-027 Counters SHALL be sized ceil(log2(max(SCAN_DIV, DB_CYCLES))) bits, minimum 1, and SHALL never wrap within a state.

Reset
REQ-028 On reset assertion, outputs SHALL immediately become cols = 4'b1110, key_code = 4'h0, key_en = 0 and key_held = 0.
REQ-029 On reset assertion, the FSM SHALL go to SCAN with col_idx = 0 and all counters and synchronizer flops cleared, synchronizer flops set to 4'hF.
REQ-030 Reset asserted in any state, including mid-debounce or HOLD, SHALL abort without emitting key_en.
REQ-031 After deassertion, scanning SHALL resume from column 0 on the next clk edge.

Verification (SCAN_DIV=4, DB_CYCLES=8)
REQ-032 The bench SHALL cover: reset, then idle with rows = 4'hF for 32 cycles -> cols cycles 1110, 1101, 1011, 0111, 1110, each held 4 cycles, with key_en never 1.
REQ-033 The bench SHALL cover: row1 low only while col2 is driven, held for 200 cycles, then released -> exactly one key_en pulse, key_code = 4'h6, and key_held high until 8 stable-high cycles after release.
REQ-034 The bench SHALL cover: row0 low on col0 for 3 cycles then high (bounce) -> no key_en, key_code unchanged, and scanning resumes on col0.
REQ-035 The bench SHALL cover: key row3/col1 ('0') held, plus row2 pressed on col1 mid-HOLD -> single key_en with key_code = 4'h0, and no second pulse until both are released.
REQ-036 The bench SHALL cover: release glitch (row high 5 cycles, low 1, high 8) during RELEASE -> key_held stays 1 until the final 8-cycle run completes, with no extra key_en.
REQ-037 The bench SHALL cover: reset asserted mid-HOLD asynchronously between clk edges -> outputs go to reset values before the next edge, and the prior key_code is cleared to 4'h0.
